ps2_key_ctrl: RTL

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
//
// Pulls bytes from a PS/2 receiver FIFO one at a time and assembles them into
// key events. E0 and F0 prefixes are folded into the event. A single-entry
// valid/ready output register holds each event until it is taken.
//
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated
// makes. A make that matches the last accepted make is suppressed, and the
// matching break re-arms the filter.
//
// Parameters
//   CNT_W       width of the make-event counter (press_cnt)
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   rest        asynchronous active-high reset
//   ready       receiver FIFO non-empty
//   data        receiver FIFO head byte
//   overflow    receiver FIFO overflow flag (sets err)
//   nextdata_n  active-low pop strobe, low for exactly one cycle per byte
//   evt_valid   key event available
//   evt_ready   consumer accepts the event this cycle
//   evt_code    scancode of the event
//   evt_ext     event carried an E0 prefix
//   evt_brk     event is a release (carried an F0 prefix)
//   press_cnt   number of emitted make events (wraps)
//   shift_held  left (0x12) or right (0x59) shift currently down
//   err         sticky error flag
//   err_clr     synchronous clear of err (a set in the same cycle wins)
// ---------------------------------------------------------------------------
module ps2_key_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic [CNT_W-1:0] press_cnt,
    output logic             shift_held,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_PAUSE = 8'hE1;
    localparam logic [7:0] K_LSHFT = 8'h12;
    localparam logic [7:0] K_RSHFT = 8'h59;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_DEC
    } state_t;

    state_t     state_q, state_d;
    logic       take;
    logic [7:0] byte_q;

    // prefix flags carried between bytes of one scancode sequence
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;

    logic       dec_now;
    logic       proto_err;
    logic       cand;       // byte is a key code (not a prefix or an error)
    logic       emit;       // key code survives the filter and becomes an event

    logic       lshift_q, rshift_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // A new byte is only taken once the output register is free or is
    // being drained this cycle, so an event is never overwritten.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready && (!evt_valid || evt_ready)) begin
                    state_d = S_POP;
                    take    = 1'b1;
                end
            end
            S_POP:   state_d = S_DEC;
            S_DEC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The pop strobe is registered from the next state. This keeps it free
    // of glitches and makes it line up exactly with the POP state.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q    <= S_IDLE;
            nextdata_n <= 1'b1;
            byte_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            nextdata_n <= (state_d != S_POP);
            if (take)
                byte_q <= data;
        end
    end

    // ------------------------------------------------------------------
    // Byte decode
    // ------------------------------------------------------------------
    // The byte is latched when the FSM enters POP. Its decode is committed
    // on the edge that leaves POP, so the resulting event is already visible
    // during DEC. That gives ready seen in N, pop in N+1 and event in N+2.
    // DEC then gives the receiver one cycle to advance its head before IDLE
    // looks at ready again.
    assign dec_now = (state_q == S_POP);

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        proto_err = 1'b0;
        cand      = 1'b0;
        if (dec_now) begin
            if (byte_q == B_PAUSE) begin
                // Pause/Break sequences are not supported; drop the byte and resync
                proto_err = 1'b1;
                ext_d     = 1'b0;
                brk_d     = 1'b0;
            end else if (byte_q == B_EXT) begin
                if (brk_q) begin
                    // F0 E0 is illegal; E0 must come before F0
                    proto_err = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else begin
                    ext_d = 1'b1;
                end
            end else if (byte_q == B_BRK) begin
                brk_d = 1'b1;   // ext is kept so that E0 F0 xx works
            end else begin
                cand  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Typematic filter
    // ------------------------------------------------------------------
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       flt_vld_q;
    logic [8:0] flt_key_q;
    logic       flt_match;

    assign flt_match = flt_vld_q && (flt_key_q == {ext_q, byte_q});

    // Only makes are suppressed. Breaks always pass through.
    always_comb begin
        emit = cand && !(flt_match && !brk_q);
    end

    // The valid bit stops a code 00 make right after reset from being
    // treated as a repeat of the cleared register.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            flt_vld_q <= 1'b0;
            flt_key_q <= 9'h000;
        end else if (cand) begin
            if (brk_q) begin
                if (flt_match)
                    flt_vld_q <= 1'b0;
            end else if (!flt_match) begin
                flt_vld_q <= 1'b1;
                flt_key_q <= {ext_q, byte_q};
            end
        end
    end
`else
    // Every make is emitted, auto-repeats included.
    always_comb begin
        emit = cand;
    end
`endif

    // ------------------------------------------------------------------
    // Event register, prefix flags, counters and status
    // ------------------------------------------------------------------
    // No event can be loaded while one is pending, because IDLE only pops
    // once the register is free. Load and drain therefore never collide.
    // Load still has priority, for robustness.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            evt_valid <= 1'b0;
            evt_code  <= 8'h00;
            evt_ext   <= 1'b0;
            evt_brk   <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            if (emit) begin
                evt_valid <= 1'b1;
                evt_code  <= byte_q;
                evt_ext   <= ext_q;
                evt_brk   <= brk_q;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest)
            press_cnt <= '0;
        else if (emit && !brk_q)
            press_cnt <= press_cnt + CNT_W'(1);
    end

    // Only the non-extended shift codes count as shift keys. The E0-prefixed
    // 12/59 sequences are fake shifts that some keyboards send.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else if (emit && !ext_q) begin
            if (byte_q == K_LSHFT)
                lshift_q <= !brk_q;
            if (byte_q == K_RSHFT)
                rshift_q <= !brk_q;
        end
    end

    assign shift_held = lshift_q | rshift_q;

    always_ff @(posedge clk or posedge rest) begin
        if (rest)
            err <= 1'b0;
        else if (overflow || proto_err)
            err <= 1'b1;
        else if (err_clr)
            err <= 1'b0;
    end

endmodule
